// File: rtl/arb_pkg.sv
// Shared types for the memory arbiter: owner encoding, requester bit positions
// in the request vector, and the starvation counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_DR   = 2'd2,
        GNT_DW   = 2'd3
    } grant_e;

    localparam int unsigned CNT_W = 4;

    localparam int REQ_I  = 0;
    localparam int REQ_DR = 1;
    localparam int REQ_DW = 2;

    // Request-vector bit owned by the given grant, used to mask the current
    // owner out of the hand-over pick.
    function automatic logic [2:0] grant_mask(grant_e g);
        logic [2:0] m;
        m = 3'b000;
        case (g)
            GNT_I:   m[REQ_I]  = 1'b1;
            GNT_DR:  m[REQ_DR] = 1'b1;
            GNT_DW:  m[REQ_DW] = 1'b1;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational priority selector: DW > DR > I, unless force_fetch_i promotes a
// pending fetch. Requesters in excl_i are never chosen.
module arb_pick
    import arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [2:0] excl_i,
    input  logic       force_fetch_i,
    output grant_e     pick_o
);

    logic [2:0] eligible;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        eligible = req_i & ~excl_i;
        pick_o   = GNT_NONE;
        if (force_fetch_i && eligible[REQ_I]) begin
            pick_o = GNT_I;
        end else if (eligible[REQ_DW]) begin
            pick_o = GNT_DW;
        end else if (eligible[REQ_DR]) begin
            pick_o = GNT_DR;
        end else if (eligible[REQ_I]) begin
            pick_o = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch, data-read and data-write masters onto a single
// req/ack memory port, with a starvation counter guaranteeing fetch progress.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                dr_req,
    input  logic [ADDR_W-1:0]   dr_addr,
    output logic                dr_ack,
    output logic [DATA_W-1:0]   dr_rdata,
    input  logic                dw_req,
    input  logic [ADDR_W-1:0]   dw_addr,
    input  logic [DATA_W-1:0]   dw_wdata,
    input  logic [DATA_W/8-1:0] dw_wstrb,
    output logic                dw_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          grant
);

    grant_e           state_q, state_d;
    grant_e           picked;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [2:0]       req_vec;
    logic             force_fetch;
    logic             grant_new;

    assign req_vec     = {dw_req, dr_req, i_req};
    assign force_fetch = i_req && (starve_q >= CNT_W'(STARVE_LIMIT));

    // In IDLE nothing is masked; during a grant the owner is masked so a
    // repeat request from it must pass through IDLE first.
    arb_pick u_pick (
        .req_i         (req_vec),
        .excl_i        (grant_mask(state_q)),
        .force_fetch_i (force_fetch),
        .pick_o        (picked)
    );

    always_comb begin
        state_d   = state_q;
        grant_new = 1'b0;
        if (state_q == GNT_NONE) begin
            if (|req_vec) begin
                state_d   = picked;
                grant_new = 1'b1;
            end
        end else if (mem_ack) begin
            state_d   = picked;
            grant_new = (picked != GNT_NONE);
        end

        starve_d = starve_q;
        if (!i_req || (grant_new && state_d == GNT_I)) begin
            starve_d = '0;
        end else if (grant_new && starve_q != '1) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= GNT_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Acks and read data are purely combinational so the requester sees the
    // memory's own latency.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        i_ack     = 1'b0;
        dr_ack    = 1'b0;
        dw_ack    = 1'b0;
        unique case (state_q)
            GNT_I: begin
                mem_req  = 1'b1;
                mem_addr = i_addr;
                i_ack    = mem_ack;
            end
            GNT_DR: begin
                mem_req  = 1'b1;
                mem_addr = dr_addr;
                dr_ack   = mem_ack;
            end
            GNT_DW: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dw_addr;
                mem_wdata = dw_wdata;
                mem_wstrb = dw_wstrb;
                dw_ack    = mem_ack;
            end
            default: ;
        endcase
    end

    assign i_rdata  = mem_rdata;
    assign dr_rdata = mem_rdata;
    assign grant    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected transfers, a
// monitor pops and compares on every memory ack; timing checks run inline.
module tb_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic [1:0]  g;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0, dr_req = 1'b0, dw_req = 1'b0;
    logic [31:0] i_addr = '0, dr_addr = '0, dw_addr = '0, dw_wdata = '0;
    logic [3:0]  dw_wstrb = '0;
    logic        i_ack, dr_ack, dw_ack;
    logic [31:0] i_rdata, dr_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  grant;
    logic        force_spur = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack), .dr_rdata(dr_rdata),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_wstrb(dw_wstrb),
        .dw_ack(dw_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [3:0] ws);
        exp_t e;
        e.g = g; e.addr = a; e.we = we; e.wdata = wd; e.wstrb = ws;
        sb.push_back(e);
    endtask

    function automatic logic ack_of(input int who);
        case (who)
            0:       return i_ack;
            1:       return dr_ack;
            default: return dw_ack;
        endcase
    endfunction

    task automatic wait_ack(input int who);
        bit done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (ack_of(who)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: requester %0d got no ack, required ack within 100 cycles", who);
        end
    endtask

    // Raise a request now, hold until ack, drop it on the following cycle.
    task automatic run_req(input int who, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
        case (who)
            0: begin i_addr = a; i_req = 1'b1; end
            1: begin dr_addr = a; dr_req = 1'b1; end
            default: begin dw_addr = a; dw_wdata = wd; dw_wstrb = ws; dw_req = 1'b1; end
        endcase
        wait_ack(who);
        tick();
        case (who)
            0: i_req = 1'b0;
            1: dr_req = 1'b0;
            default: dw_req = 1'b0;
        endcase
    endtask

    // Memory model: ack LAT cycles after the first cycle a transfer is presented.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (mem_ack) cnt = 0;
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (cnt == LAT) begin
                        mem_ack = 1'b1;
                        mem_rdata = rd_fn(mem_addr);
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
                if (force_spur) begin
                    mem_ack = 1'b1;
                    mem_rdata = 32'h0BAD_0BAD;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        logic [2:0] want_acks;
        forever begin
            @(negedge clk);
            if (mem_ack && reset_n) begin
                if (!mem_req) begin
                    check("idle_ack_suppressed", {dw_ack, dr_ack, i_ack}, 3'b000);
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer: grant %0d addr %0h, required no transfer", grant, mem_addr);
                end else begin
                    e = sb.pop_front();
                    case (e.g)
                        2'd1:    want_acks = 3'b001;
                        2'd2:    want_acks = 3'b010;
                        default: want_acks = 3'b100;
                    endcase
                    check("sb_grant", grant, e.g);
                    check("sb_addr", mem_addr, e.addr);
                    check("sb_we", mem_we, e.we);
                    check("sb_acks", {dw_ack, dr_ack, i_ack}, want_acks);
                    if (e.we) begin
                        check("sb_wdata", mem_wdata, e.wdata);
                        check("sb_wstrb", mem_wstrb, e.wstrb);
                    end else if (e.g == 2'd1) begin
                        check("sb_i_rdata", i_rdata, rd_fn(e.addr));
                    end else begin
                        check("sb_dr_rdata", dr_rdata, rd_fn(e.addr));
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_grant", grant, 0);
        check("rst_acks", {dw_ack, dr_ack, i_ack}, 0);
        check("rst_mem_addr", mem_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_counter", dut.starve_q, 0);

        // Single fetch
        tick();
        push(2'd1, 32'h100, 1'b0, '0, '0);
        i_addr = 32'h100;
        i_req = 1'b1;
        @(negedge clk);
        check("fetch_req_not_yet", mem_req, 0);
        @(negedge clk);
        check("fetch_req_latency", mem_req, 1);
        check("fetch_grant", grant, 1);
        @(negedge clk);
        check("fetch_no_early_ack", i_ack, 0);
        @(negedge clk);
        check("fetch_ack", i_ack, 1);
        tick();
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_grant_release", grant, 0);

        // All three requesters together: DW, DR, I back-to-back
        tick();
        push(2'd3, 32'h200, 1'b1, 32'h1122_3344, 4'hF);
        push(2'd2, 32'h300, 1'b0, '0, '0);
        push(2'd1, 32'h104, 1'b0, '0, '0);
        fork
            run_req(2, 32'h200, 32'h1122_3344, 4'hF);
            run_req(1, 32'h300, '0, '0);
            run_req(0, 32'h104, '0, '0);
            begin
                bit seen = 1'b0;
                int idle = 0;
                int acks = 0;
                for (int n = 0; n < 10 && !seen; n++) begin
                    @(negedge clk);
                    seen = mem_req;
                end
                check("tri_mem_req_seen", seen, 1);
                check("tri_first_grant", grant, 3);
                check("tri_first_we", mem_we, 1);
                check("tri_first_wstrb", mem_wstrb, 4'hF);
                for (int n = 0; n < 40 && acks < 3; n++) begin
                    @(negedge clk);
                    if (!mem_req) idle++;
                    if (mem_ack) acks++;
                end
                check("tri_acks", acks, 3);
                check("tri_idle_cycles", idle, 0);
            end
        join

        // Starvation: fetch forced in after four data grants
        repeat (2) tick();
        push(2'd3, 32'h400, 1'b1, 32'hCAFE_0000, 4'hF);
        push(2'd2, 32'h500, 1'b0, '0, '0);
        push(2'd3, 32'h404, 1'b1, 32'hCAFE_0001, 4'hF);
        push(2'd2, 32'h504, 1'b0, '0, '0);
        push(2'd1, 32'h108, 1'b0, '0, '0);
        push(2'd3, 32'h408, 1'b1, 32'hCAFE_0002, 4'hF);
        fork
            begin
                for (int k = 0; k < 3; k++)
                    run_req(2, 32'h400 + 32'(k * 4), 32'hCAFE_0000 + 32'(k), 4'hF);
            end
            begin
                for (int k = 0; k < 2; k++)
                    run_req(1, 32'h500 + 32'(k * 4), '0, '0);
            end
            run_req(0, 32'h108, '0, '0);
            begin
                logic [1:0] prev = 2'd0;
                int data_grants = 0;
                bit got_i = 1'b0;
                for (int n = 0; n < 80 && !got_i; n++) begin
                    @(negedge clk);
                    if (grant == 2'd1) begin
                        got_i = 1'b1;
                    end else if (grant != prev && grant != 2'd0) begin
                        data_grants++;
                    end
                    prev = grant;
                end
                check("starve_i_granted", got_i, 1);
                check("starve_data_grants", data_grants, 4);
                check("starve_counter_cleared", dut.starve_q, 0);
            end
        join

        // Back-to-back DR: one IDLE cycle between the two transfers
        repeat (2) tick();
        push(2'd2, 32'h600, 1'b0, '0, '0);
        push(2'd2, 32'h604, 1'b0, '0, '0);
        dr_addr = 32'h600;
        dr_req = 1'b1;
        wait_ack(1);
        tick();
        dr_addr = 32'h604;
        @(negedge clk);
        check("b2b_idle_mem_req", mem_req, 0);
        check("b2b_idle_grant", grant, 0);
        @(negedge clk);
        check("b2b_regrant_mem_req", mem_req, 1);
        check("b2b_regrant_grant", grant, 2);
        wait_ack(1);
        tick();
        dr_req = 1'b0;

        // Reset mid-transfer during GNT_DW
        repeat (2) tick();
        push(2'd3, 32'h700, 1'b1, 32'hDEAD_0700, 4'h3);
        fork
            run_req(2, 32'h700, 32'hDEAD_0700, 4'h3);
            begin
                @(negedge clk);
                @(negedge clk);
                check("rst_mid_grant_before", grant, 3);
                #2;
                reset_n = 1'b0;
                #1;
                check("rst_mid_mem_req", mem_req, 0);
                check("rst_mid_dw_ack", dw_ack, 0);
                check("rst_mid_grant", grant, 0);
                check("rst_mid_mem_we", mem_we, 0);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                @(negedge clk);
                check("rst_release_idle", grant, 0);
                @(negedge clk);
                check("rst_release_regrant", grant, 3);
            end
        join

        // Spurious mem_ack in IDLE
        repeat (2) tick();
        force_spur = 1'b1;
        @(negedge clk);
        check("spur_ack_seen", mem_ack, 1);
        check("spur_acks", {dw_ack, dr_ack, i_ack}, 0);
        check("spur_grant", grant, 0);
        tick();
        force_spur = 1'b0;
        @(negedge clk);
        check("spur_stays_idle", grant, 0);
        check("spur_mem_req", mem_req, 0);

        repeat (3) tick();
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
